// File: rtl/controlador_display_if.sv
// Value handshake and display bus between a producer and controlador_display.
// The producer drives num_in/num_valid. The controller returns num_ready and
// the scanned digit outputs.
interface controlador_display_if;
   logic [7:0] num_in;
   logic       num_valid;
   logic       num_ready;
   logic [3:0] digit_bcd;
   logic [2:0] digit_sel;
   logic       sat;

   modport master (
      output num_in, num_valid,
      input  num_ready, digit_bcd, digit_sel, sat
   );

   modport slave (
      input  num_in, num_valid,
      output num_ready, digit_bcd, digit_sel, sat
   );
endinterface

// File: rtl/controlador_display.sv
// controlador_display: converts an 8-bit value (clamped to 150) into three BCD
// digits with a serial double-dabble engine. It then time-multiplexes one
// shared Decodificador9 across centenas/decenas/unidades. Each digit is
// selected in turn, and leading zeros can optionally be blanked.
module controlador_display #(
   parameter int SCAN_DIV      = 50000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic            clk,
   input logic            rst,
   controlador_display_if.slave bus
);

   localparam int CW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   state_t        state_r;
   logic [7:0]    bin_r;
   logic [11:0]   bcd_r;
   logic [2:0]    iter_r;
   logic          clamp_r;
   logic          ready_r;
   logic [3:0]    cen_r;
   logic [3:0]    dec_r;
   logic [3:0]    uni_r;
   logic          sat_r;

   logic [CW-1:0] scan_cnt_r;
   logic [1:0]    digit_r;      // 0 = unidades, 1 = decenas, 2 = centenas

   logic [11:0]   bcd_adj_s;
   logic          cen_blank_s;
   logic          dec_blank_s;
   logic [3:0]    digit_bcd_s;
   logic [2:0]    digit_sel_s;

   // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
   function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = r[i*4 +: 4];
         end
      end
      return r;
   endfunction

   // Correction applied to the accumulator ahead of each conversion shift.
   always_comb begin
      bcd_adj_s = dabble_adjust(bcd_r);
   end

   // Conversion FSM: accept, shift-add-3 for eight iterations, commit to the display.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         bin_r   <= 8'd0;
         bcd_r   <= 12'd0;
         iter_r  <= 3'd0;
         clamp_r <= 1'b0;
         ready_r <= 1'b0;
         cen_r   <= 4'd0;
         dec_r   <= 4'd0;
         uni_r   <= 4'd0;
         sat_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ready_r && bus.num_valid) begin
                  bin_r   <= (bus.num_in > 8'd150) ? 8'd150 : bus.num_in;
                  clamp_r <= (bus.num_in > 8'd150);
                  bcd_r   <= 12'd0;
                  iter_r  <= 3'd0;
                  ready_r <= 1'b0;
                  state_r <= ST_CONVERT;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ST_CONVERT: begin
               bcd_r  <= {bcd_adj_s[10:0], bin_r[7]};
               bin_r  <= {bin_r[6:0], 1'b0};
               iter_r <= iter_r + 3'd1;
               if (iter_r == 3'd7) begin
                  state_r <= ST_COMMIT;
               end else begin
                  state_r <= ST_CONVERT;
               end
            end
            ST_COMMIT: begin
               cen_r   <= bcd_r[11:8];
               dec_r   <= bcd_r[7:4];
               uni_r   <= bcd_r[3:0];
               sat_r   <= clamp_r;
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Scan engine: hold each digit for SCAN_DIV cycles, then rotate unidades -> decenas -> centenas.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_r <= '0;
         digit_r    <= 2'd0;
      end else if (scan_cnt_r == CW'(SCAN_DIV - 1)) begin
         scan_cnt_r <= '0;
         digit_r    <= (digit_r == 2'd2) ? 2'd0 : digit_r + 2'd1;
      end else begin
         scan_cnt_r <= scan_cnt_r + CW'(1);
      end
   end

   // Digit mux and leading-zero blanking, decoded from registers only.
   always_comb begin
      cen_blank_s = BLANK_LEADING && (cen_r == 4'd0);
      dec_blank_s = BLANK_LEADING && (cen_r == 4'd0) && (dec_r == 4'd0);
      digit_bcd_s = 4'd0;
      digit_sel_s = 3'b000;
      case (digit_r)
         2'd0: begin
            digit_bcd_s = uni_r;
            digit_sel_s = 3'b001;
         end
         2'd1: begin
            digit_bcd_s = dec_r;
            digit_sel_s = dec_blank_s ? 3'b000 : 3'b010;
         end
         2'd2: begin
            digit_bcd_s = cen_r;
            digit_sel_s = cen_blank_s ? 3'b000 : 3'b100;
         end
         default: begin
            digit_bcd_s = 4'd0;
            digit_sel_s = 3'b000;
         end
      endcase
   end

   assign bus.num_ready = ready_r;
   assign bus.digit_bcd = digit_bcd_s;
   assign bus.digit_sel = digit_sel_s;
   assign bus.sat       = sat_r;

endmodule

// File: tb/tb_controlador_display.sv
// Bench for controlador_display. It runs two instances, one with leading-zero
// blanking and one without, from the same stimulus. A cycle-level reference
// model derives every output from the decimal value, the elapsed-cycle count
// and the accept countdown.
module tb_controlador_display;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] num_in = 8'd0;
   logic       num_valid = 1'b0;
   logic       checking = 1'b0;
   int         cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   controlador_display_if ifa ();
   controlador_display_if ifb ();

   assign ifa.num_in    = num_in;
   assign ifa.num_valid = num_valid;
   assign ifb.num_in    = num_in;
   assign ifb.num_valid = num_valid;

   controlador_display #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave)
   );
   controlador_display #(.SCAN_DIV(SD), .BLANK_LEADING(1'b0)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave)
   );

   // Reference model state.
   int   m_edges = 0;
   int   m_cd    = 0;
   logic m_ready = 1'b0;
   int   m_cen = 0, m_dec = 0, m_uni = 0;
   logic m_sat   = 1'b0;
   int   m_pend  = 0;
   logic m_pclamp = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Free-running edge counter used to measure accept spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: accept, a 9-edge busy countdown, then decimal split of the clamped value.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edges <= 0;
         m_cd    <= 0;
         m_ready <= 1'b0;
         m_cen   <= 0;
         m_dec   <= 0;
         m_uni   <= 0;
         m_sat   <= 1'b0;
      end else begin
         m_edges <= m_edges + 1;
         if (m_cd > 0) begin
            m_cd <= m_cd - 1;
            if (m_cd == 1) begin
               m_cen   <= m_pend / 100;
               m_dec   <= (m_pend / 10) % 10;
               m_uni   <= m_pend % 10;
               m_sat   <= m_pclamp;
               m_ready <= 1'b1;
            end
         end else if (m_ready && num_valid) begin
            m_pend   <= (num_in > 8'd150) ? 150 : int'(num_in);
            m_pclamp <= (num_in > 8'd150);
            m_cd     <= 9;
            m_ready  <= 1'b0;
         end else begin
            m_ready <= 1'b1;
         end
      end
   end

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (checking) begin
         int idx;
         int ebcd;
         logic [2:0] esel_a, esel_b;
         logic blank;
         idx  = (m_edges / SD) % 3;
         ebcd = (idx == 0) ? m_uni : ((idx == 1) ? m_dec : m_cen);
         blank = ((idx == 2) && (m_cen == 0)) || ((idx == 1) && (m_cen == 0) && (m_dec == 0));
         esel_b = 3'b001 << idx;
         esel_a = blank ? 3'b000 : esel_b;
         check("ready_a", ifa.num_ready, m_ready);
         check("ready_b", ifb.num_ready, m_ready);
         check("bcd_a",   ifa.digit_bcd, ebcd);
         check("bcd_b",   ifb.digit_bcd, ebcd);
         check("sel_a",   ifa.digit_sel, esel_a);
         check("sel_b",   ifb.digit_sel, esel_b);
         check("sat_a",   ifa.sat, m_sat);
         check("sat_b",   ifb.sat, m_sat);
      end
   end

   // Present v until accepted (bounded); optionally keep num_valid high afterwards.
   task automatic send(input logic [7:0] v, input bit hold, output int acc_edge);
      logic r;
      acc_edge  = -1;
      num_in    = v;
      num_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         r = ifa.num_ready;
         @(posedge clk);
         #2;
         if (r) begin
            acc_edge = cyc;
            break;
         end
      end
      if (!hold) num_valid = 1'b0;
      n_checks++;
      if (acc_edge < 0) begin
         n_fail++;
         $display("FAIL accept_timeout: value %0d never accepted", v);
      end
   endtask

   // Watch one full scan rotation and record what each enabled digit showed.
   task automatic observe(output logic [11:0] a_vals, output logic [2:0] a_seen,
                          output logic [11:0] b_vals, output logic [2:0] b_seen);
      a_vals = 12'd0; a_seen = 3'b000;
      b_vals = 12'd0; b_seen = 3'b000;
      repeat (3 * SD + 1) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (ifa.digit_sel[k]) begin
               a_seen[k] = 1'b1;
               a_vals[k*4 +: 4] = ifa.digit_bcd;
            end
            if (ifb.digit_sel[k]) begin
               b_seen[k] = 1'b1;
               b_vals[k*4 +: 4] = ifb.digit_bcd;
            end
         end
      end
   endtask

   task automatic settle();
      repeat (11) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [11:0] av, bv;
      logic [2:0]  as_, bs;
      int e1, e2, low;

      #1 rst = 1'b1;
      #1 checking = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      check("rst_ready", ifa.num_ready, 1);
      check("rst_sel",   ifa.digit_sel, 3'b001);
      check("rst_bcd",   ifa.digit_bcd, 0);
      check("rst_sat",   ifa.sat, 0);

      // 137: busy window and digit pattern.
      send(8'd137, 1'b0, e1);
      low = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifa.num_ready) break;
         low++;
      end
      check("busy_len", low, 9);
      observe(av, as_, bv, bs);
      check("d137_vals", av, 12'h137);
      check("d137_seen", as_, 3'b111);

      // Clamp, then a two-digit value.
      send(8'd200, 1'b0, e1); settle();
      check("clamp_sat", ifa.sat, 1);
      observe(av, as_, bv, bs);
      check("clamp_vals", av, 12'h150);
      send(8'd42, 1'b0, e1); settle();
      check("v42_sat", ifa.sat, 0);
      observe(av, as_, bv, bs);
      check("v42_seen", as_, 3'b011);
      check("v42_vals", av[7:0], 8'h42);

      // Zero with and without blanking.
      send(8'd0, 1'b0, e1); settle();
      observe(av, as_, bv, bs);
      check("zero_seen_a", as_, 3'b001);
      check("zero_val_a",  av[3:0], 0);
      check("zero_seen_b", bs, 3'b111);
      check("zero_vals_b", bv, 12'h000);

      // Exactly 150.
      send(8'd150, 1'b0, e1); settle();
      check("v150_sat", ifa.sat, 0);
      observe(av, as_, bv, bs);
      check("v150_vals", av, 12'h150);

      // Back-to-back: 55 held during conversion of 99.
      send(8'd99, 1'b1, e1);
      send(8'd55, 1'b0, e2);
      check("b2b_spacing", e2 - e1, 10);
      settle();
      observe(av, as_, bv, bs);
      check("b2b_seen", as_, 3'b011);
      check("b2b_vals", av[7:0], 8'h55);

      // Reset during the 5th conversion cycle of 123.
      send(8'd123, 1'b0, e1);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("mid_rst_ready", ifa.num_ready, 0);
      check("mid_rst_bcd",   ifb.digit_bcd, 0);
      rst = 1'b0;
      send(8'd88, 1'b0, e1); settle();
      observe(av, as_, bv, bs);
      check("v88_seen", as_, 3'b011);
      check("v88_vals", av[7:0], 8'h88);

      // Randomized traffic, including held valids and one random reset.
      for (int t = 0; t < 40; t++) begin
         send(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), e1);
         repeat ($urandom_range(0, 14)) @(posedge clk);
         #2;
         num_valid = 1'b0;
         if (t == 20) begin
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #2 rst = 1'b1;
            repeat (2) @(posedge clk);
            #2 rst = 1'b0;
         end
      end
      settle();
      observe(av, as_, bv, bs);

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
